icache_fetch_responder: RTL and testbench

ICACHE_FETCH_RESPONDER -- requirements
Module: icache_fetch_responder

---
 rtl/icache_fetch_responder.sv | 198 +++++++++++++++++++
 tb/tb_icache_fetch_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache fetch responder.
// Hit/fault in one cycle; misses refill a 4-word line.
module icache_fetch_responder #(
   parameter int ADDR_W     = 40,
   parameter int INDEX_BITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [31:0]       fetch_inst,
   output logic              fetch_err,
   input  logic              fetch_cancel,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_err
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - 4 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      DRAIN
   } stateE;

   stateE state;
   stateE stateNext;

   logic [LINES-1:0] lineValid;
   logic [TAG_W-1:0] tagArr [LINES];
   logic [31:0]      dataArr [LINES*4];

   logic [INDEX_BITS-1:0] aIdx;
   logic [TAG_W-1:0]      aTag;
   logic [1:0]            aOff;

   logic [INDEX_BITS-1:0] reqIdx;
   logic [TAG_W-1:0]      reqTag;
   logic [1:0]            reqOff;
   logic [1:0]            beatCnt;
   logic                  cancelLat;
   logic                  flushLat;

   logic        accept;
   logic        misalign;
   logic        hit;
   logic        busy;
   logic        beatDone;
   logic        lastBeat;
   logic        errBeat;
   logic        cancelNow;
   logic [31:0] hitWord;
   logic [31:0] respWord;

   assign aOff = fetch_addr[3:2];
   assign aIdx = fetch_addr[3+INDEX_BITS:4];
   assign aTag = fetch_addr[ADDR_W-1:4+INDEX_BITS];

   assign fetch_ready = (state == IDLE) && !flush;
   assign accept      = fetch_req && fetch_ready;
   assign misalign    = (fetch_addr[1:0] != 2'b00);
   assign hit         = lineValid[aIdx] && (tagArr[aIdx] == aTag);
   assign hitWord     = dataArr[{aIdx, aOff}];

   assign busy      = (state != IDLE);
   assign beatDone  = busy && mem_req && mem_ack;
   assign errBeat   = beatDone && mem_err;
   assign lastBeat  = beatDone && !mem_err && (beatCnt == 2'd3);
   assign cancelNow = cancelLat || fetch_cancel;

   // The requested word may be arriving on this very beat.
   assign respWord = (beatCnt == reqOff) ? mem_rdata
                                         : dataArr[{reqIdx, reqOff}];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state: cancel during refill diverts to DRAIN.
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (accept && !misalign && !hit) begin
               stateNext = REFILL;
            end
         end
         REFILL: begin
            if (errBeat || lastBeat) begin
               stateNext = IDLE;
            end else if (cancelNow) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (errBeat || lastBeat) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Responses, refill sequencing and line valid bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_valid <= 1'b0;
         fetch_err   <= 1'b0;
         fetch_inst  <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         lineValid   <= '0;
         cancelLat   <= 1'b0;
         flushLat    <= 1'b0;
         reqIdx      <= '0;
         reqTag      <= '0;
         reqOff      <= '0;
         beatCnt     <= '0;
      end else begin
         fetch_valid <= 1'b0;
         fetch_err   <= 1'b0;
         fetch_inst  <= '0;

         if (flush) begin
            lineValid <= '0;
         end

         if (accept) begin
            if (misalign) begin
               fetch_valid <= !fetch_cancel;
               fetch_err   <= 1'b1;
            end else if (hit) begin
               fetch_valid <= !fetch_cancel;
               fetch_inst  <= fetch_cancel ? 32'h0 : hitWord;
            end else begin
               reqIdx          <= aIdx;
               reqTag          <= aTag;
               reqOff          <= aOff;
               beatCnt         <= 2'd0;
               mem_req         <= 1'b1;
               mem_addr        <= {fetch_addr[ADDR_W-1:4], 4'b0000};
               cancelLat       <= fetch_cancel;
               flushLat        <= 1'b0;
               lineValid[aIdx] <= 1'b0;
            end
         end

         if (busy) begin
            if (fetch_cancel) begin
               cancelLat <= 1'b1;
            end
            if (flush) begin
               flushLat <= 1'b1;
            end
            if (errBeat) begin
               mem_req     <= 1'b0;
               cancelLat   <= 1'b0;
               fetch_valid <= !cancelNow;
               fetch_err   <= !cancelNow;
            end else if (lastBeat) begin
               mem_req     <= 1'b0;
               cancelLat   <= 1'b0;
               fetch_valid <= !cancelNow;
               fetch_inst  <= cancelNow ? 32'h0 : respWord;
               if (!flush && !flushLat) begin
                  lineValid[reqIdx] <= 1'b1;
               end
            end else if (beatDone) begin
               beatCnt  <= beatCnt + 2'd1;
               mem_addr <= mem_addr + ADDR_W'(4);
            end
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them.
   always_ff @(posedge clk) begin
      if (beatDone && !mem_err) begin
         dataArr[{reqIdx, beatCnt}] <= mem_rdata;
      end
      if (lastBeat) begin
         tagArr[reqIdx] <= reqTag;
      end
   end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder.
// Cycle table for the basic flow, hand sequences for corner cases.
module tb_icache_fetch_responder;

   logic        clk;
   logic        rst;
   logic        fetch_req;
   logic [39:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_inst;
   logic        fetch_err;
   logic        fetch_cancel;
   logic        flush;
   logic        mem_req;
   logic [39:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;

   logic        errEn;
   logic [39:0] errAddr;
   int          beats;
   int          checks;
   int          failures;

   icache_fetch_responder #(.ADDR_W(40), .INDEX_BITS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ready  (fetch_ready),
      .fetch_valid  (fetch_valid),
      .fetch_inst   (fetch_inst),
      .fetch_err    (fetch_err),
      .fetch_cancel (fetch_cancel),
      .flush        (flush),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .mem_err      (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns 0xA0+word for line 0x1xx, plus 0x10000 per 0x100 step.
   function automatic logic [31:0] memWord(input logic [39:0] a);
      logic [31:0] hi;
      logic [31:0] lo;
      hi = (32'(a[11:8]) - 32'd1) << 16;
      lo = 32'hA0 + 32'(a[3:2]);
      return hi | lo;
   endfunction

   assign mem_ack   = mem_req;
   assign mem_rdata = mem_req ? memWord(mem_addr) : 32'h0;
   assign mem_err   = mem_req && errEn && (mem_addr == errAddr);

   always @(negedge clk) begin
      if (mem_req && mem_ack) beats++;
   end

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request cycle; returns one cycle after the accept edge.
   task automatic startFetch(input logic [39:0] a, input logic c);
      fetch_req    = 1'b1;
      fetch_addr   = a;
      fetch_cancel = c;
      tick();
      fetch_req    = 1'b0;
      fetch_cancel = 1'b0;
   endtask

   // Wait for a response; lat = edges since accept, 0 on timeout.
   task automatic waitResp(input int base, output int lat,
                           output logic [31:0] inst, output logic err);
      lat  = 0;
      inst = 32'hDEAD;
      err  = 1'b0;
      for (int n = base; n < base + 20; n++) begin
         @(negedge clk);
         if (fetch_valid) begin
            lat  = n;
            inst = fetch_inst;
            err  = fetch_err;
            break;
         end
         tick();
      end
      if (lat != 0) begin
         tick();
         @(negedge clk);
         check("single_pulse", 128'(fetch_valid), 128'(0));
      end
      tick();
   endtask

   task automatic doFetch(input logic [39:0] a, output int lat,
                          output logic [31:0] inst, output logic err);
      startFetch(a, 1'b0);
      waitResp(1, lat, inst, err);
   endtask

   typedef struct {
      logic        req;
      logic [39:0] addr;
      logic        expReady;
      logic        expValid;
      logic        expErr;
      logic [31:0] expInst;
      logic        expMemReq;
      logic [39:0] expMemAddr;
   } vecT;

   vecT vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] inst;
      logic        err;
      int          seen;

      checks       = 0;
      failures     = 0;
      beats        = 0;
      errEn        = 1'b0;
      errAddr      = 40'h0;
      rst          = 1'b1;
      fetch_req    = 1'b0;
      fetch_addr   = 40'h0;
      fetch_cancel = 1'b0;
      flush        = 1'b0;

      vecs[0] = '{1'b1, 40'h104, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 40'h0};
      vecs[1] = '{1'b0, 40'h0,   1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 40'h100};
      vecs[2] = '{1'b0, 40'h0,   1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 40'h104};
      vecs[3] = '{1'b0, 40'h0,   1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 40'h108};
      vecs[4] = '{1'b0, 40'h0,   1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 40'h10C};
      vecs[5] = '{1'b1, 40'h108, 1'b1, 1'b1, 1'b0, 32'hA1, 1'b0, 40'h10C};
      vecs[6] = '{1'b1, 40'h10C, 1'b1, 1'b1, 1'b0, 32'hA2, 1'b0, 40'h10C};
      vecs[7] = '{1'b1, 40'h102, 1'b1, 1'b1, 1'b0, 32'hA3, 1'b0, 40'h10C};
      vecs[8] = '{1'b0, 40'h0,   1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 40'h10C};
      vecs[9] = '{1'b0, 40'h0,   1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 40'h10C};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            {fetch_valid, fetch_err, fetch_inst, mem_req, mem_addr},
            128'(0));
      tick();
      rst = 1'b0;

      // Cold miss, back-to-back hits, misaligned fault.
      for (int i = 0; i < 10; i++) begin
         fetch_req  = vecs[i].req;
         fetch_addr = vecs[i].addr;
         @(negedge clk);
         check($sformatf("vec%0d", i),
               {fetch_ready, fetch_valid, fetch_err, fetch_inst,
                mem_req, mem_addr},
               {vecs[i].expReady, vecs[i].expValid, vecs[i].expErr,
                vecs[i].expInst, vecs[i].expMemReq, vecs[i].expMemAddr});
         tick();
      end
      fetch_req = 1'b0;

      // Hit, then one-cycle flush, then the same address misses.
      doFetch(40'h100, lat, inst, err);
      check("pre_flush_lat", 128'(lat), 128'(1));
      check("pre_flush_inst", 128'(inst), 128'(32'hA0));
      flush = 1'b1;
      @(negedge clk);
      check("flush_ready", 128'(fetch_ready), 128'(0));
      tick();
      flush = 1'b0;
      doFetch(40'h100, lat, inst, err);
      check("post_flush_lat", 128'(lat), 128'(5));
      check("post_flush_inst", 128'(inst), 128'(32'hA0));

      // Bus error on second beat, then a clean refetch.
      errEn   = 1'b1;
      errAddr = 40'h204;
      doFetch(40'h200, lat, inst, err);
      check("err_lat", 128'(lat), 128'(3));
      check("err_resp", {err, inst}, {1'b1, 32'h0});
      @(negedge clk);
      check("err_memreq", 128'(mem_req), 128'(0));
      tick();
      errEn = 1'b0;
      doFetch(40'h200, lat, inst, err);
      check("err_refetch_lat", 128'(lat), 128'(5));
      check("err_refetch", {err, inst}, {1'b0, 32'h100A0});

      // Cancel on the first beat: refill completes silently.
      beats = 0;
      seen  = 0;
      startFetch(40'h300, 1'b0);
      fetch_cancel = 1'b1;
      tick();
      fetch_cancel = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (fetch_valid) seen++;
         tick();
      end
      check("cancel_beats", 128'(beats), 128'(4));
      check("cancel_no_resp", 128'(seen), 128'(0));
      check("cancel_ready", {fetch_ready, mem_req}, {1'b1, 1'b0});
      doFetch(40'h300, lat, inst, err);
      check("cancel_refetch_lat", 128'(lat), 128'(1));
      check("cancel_refetch", 128'(inst), 128'(32'h200A0));

      // Cancel together with a hit accept suppresses the response.
      seen = 0;
      startFetch(40'h308, 1'b1);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (fetch_valid) seen++;
         tick();
      end
      check("idle_cancel", 128'(seen), 128'(0));
      doFetch(40'h308, lat, inst, err);
      check("idle_cancel_hit", {32'(lat), inst}, {32'd1, 32'h200A2});

      // Flush mid-refill: response delivered, line left invalid.
      startFetch(40'h44C, 1'b0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      waitResp(3, lat, inst, err);
      check("flush_refill_lat", 128'(lat), 128'(5));
      check("flush_refill", {err, inst}, {1'b0, 32'h300A3});
      doFetch(40'h44C, lat, inst, err);
      check("flush_refill_again", 128'(lat), 128'(5));

      // Reset mid-refill abandons the line.
      startFetch(40'h584, 1'b0);
      @(negedge clk);
      check("rst_pre_memreq", 128'(mem_req), 128'(1));
      tick();
      rst = 1'b1;
      #1;
      check("rst_async", {mem_req, fetch_valid, mem_addr},
            {1'b0, 1'b0, 40'h0});
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_release", 128'(mem_req), 128'(0));
      tick();
      doFetch(40'h584, lat, inst, err);
      check("rst_refetch_lat", 128'(lat), 128'(5));
      check("rst_refetch", 128'(inst), 128'(32'h400A1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
